dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the core's load/store port: services d_addr/d_we/d_wr_data, returns d_rd_data one cycle later.
//  Aligns lanes (core issues low-lane data + low-aligned byte mask), hosts word RAM plus MMIO: console TX FIFO, GPIO, cycle counter.
//  Sits between core LSU port and top-level pins; no stall path, always ready.
// PARAMETERS
//  RAM_AW      12  RAM depth = 2**RAM_AW 32-bit words (byte addr bits [RAM_AW+1:2])
//  FIFO_DEPTH  8   TX FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  d_addr     in   32  byte address, valid every cycle (reads implicit)
//  d_we       in   4   low-aligned byte mask (0001 B, 0011 H, 1111 W); 0 = read
//  d_wr_data  in   32  store data, low-lane aligned
//  d_rd_data  out  32  load data for previous cycle's d_addr, shifted to low lane
//  tx_valid   out  1   TX FIFO non-empty
//  tx_data    out  8   TX FIFO head byte
//  tx_ready   in   1   consumer pops head when tx_valid & tx_ready
//  gpio_out   out  32  GPIO register
//  misalign   out  1   1-cycle pulse: access crosses word boundary
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst synchronous active-high. Timing below is per posedge clk.
//  Decode on d_addr:
//   [31:28]==0                      RAM
//   0x1000_0000 TXDATA  wr: push d_wr_data[7:0]; rd: {29'b0,ovf,full,empty}
//   0x1000_0004 CYCLE   rd-only
//   0x1000_0008 GPIO    rd/wr, byte-masked
//   other: reads 0, writes dropped.
//  MMIO is word-addressed: d_addr[1:0] ignored; no lane shift.
//  Lane align (RAM), off = d_addr[1:0]:
//   write mask = d_we << off; data = d_wr_data << 8*off.
//   read: d_rd_data = word >> 8*off_q; off_q is registered.
//  Misaligned: (mask 0011 & off==3) | (mask 1111 & off!=0).
//   Write: suppressed entirely, misalign pulses the next cycle.
//   Read cannot be detected (d_we==0): returns shifted word, upper bytes 0.
//  Latency: d_rd_data valid exactly 1 cycle after d_addr. Region select and offset are registered alongside RAM read.
//  Read during a write to the same word in the same cycle is read-first: returns old data.
//   Next-cycle read returns new data.
//  TX FIFO:
//   push = TXDATA write with d_we[0].
//   pop  = tx_valid & tx_ready; tx_data = head (registered storage, not a bypass).
//   Push while full with no same-cycle pop: dropped, ovf sticky set.
//   Push while full with same-cycle pop: accepted.
//   Push+pop on empty: entry written, tx_valid 1 next cycle.
//   ovf clears on a TXDATA status read (clears the cycle after the read is issued; the read returns ovf=1).
//   Pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  GPIO write honours d_we bits directly (no shift).
//  Reset values: d_rd_data 0 (region_q = none), tx_valid 0, tx_data 0, gpio_out 0, misalign 0, FIFO empty, ovf 0, cycle 0.
//   RAM contents not reset.
//   Reset asserted mid-traffic: the same-cycle write is discarded and the FIFO is flushed.
// CONFIGURATION
//  DMEM_CYCLE_CTR_EN defined:
//   32-bit free-running counter, +1 per cycle, wraps 0xFFFF_FFFF -> 0.
//   CYCLE read returns the count sampled on the cycle the address is presented.
//  Undefined: no counter logic; CYCLE reads 0.
// TESTING
//  1 SW 0xDEADBEEF @0x100, then LW @0x100 -> d_rd_data 0xDEADBEEF one cycle after read addr.
//  2 SB d_wr_data=0xAB d_we=0001 @0x103 over 0x11223344, then LBU-style read @0x103 -> 0x000000AB; LW @0x100 -> 0xAB223344.
//  3 SH d_we=0011 @0x103 -> write suppressed, misalign=1 next cycle; word @0x100 unchanged.
//  4 9 TXDATA writes with tx_ready=0, FIFO_DEPTH=8:
//     - status read -> 0x6 (full, ovf).
//     - Re-read -> 0x2.
//     - tx_ready=1 -> bytes drained in order, tx_valid falls after 8th.
//  5 Full FIFO + push + pop same cycle -> push accepted, count stays 8, ovf stays 0.
//  6 CYCLE read at cycles 10, 11 after reset (DMEM_CYCLE_CTR_EN): consecutive values differ by 1; without macro -> 0. Assert rst mid-FIFO-fill -> tx_valid 0 next cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: core data-port responder with lane-aligned word RAM and MMIO (console TX FIFO, GPIO, cycle counter); cycle counter enabled by DMEM_CYCLE_CTR_EN
module dmem_responder #(
  parameter int RAM_AW = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        misalign
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {R_NONE, R_RAM, R_MMIO} region_t;
  region_t region_q;
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] ram_q, mmio_q, mmio_rd, cycle, wdata;
  logic [RAM_AW-1:0] idx;
  logic [1:0] off, off_q;
  logic [7:0] wmask;
  logic is_ram, is_tx, is_cyc, is_gpio, mis, ram_we;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic ovf, full, push_req, push, pop;
  assign idx = d_addr[RAM_AW+1:2];
  assign off = d_addr[1:0];
  assign is_ram = d_addr[31:28] == 4'h0;
  assign is_tx = d_addr[31:2] == 30'h0400_0000;
  assign is_cyc = d_addr[31:2] == 30'h0400_0001;
  assign is_gpio = d_addr[31:2] == 30'h0400_0002;
  assign wmask = {4'b0, d_we} << off;
  assign wdata = d_wr_data << {off, 3'b0};
  assign mis = |wmask[7:4];
  assign ram_we = is_ram & ~rst & ~mis & |d_we;
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  assign tx_valid = cnt != '0;
  assign tx_data = tx_valid ? fifo[rp] : 8'h0;
  assign pop = tx_valid & tx_ready;
  assign push_req = is_tx & d_we[0];
  assign push = push_req & (~full | pop);
  assign mmio_rd = is_tx ? {29'b0, ovf, full, ~tx_valid} : is_cyc ? cycle : is_gpio ? gpio_out : 32'h0;
  assign d_rd_data = region_q == R_RAM ? ram_q >> {off_q, 3'b0} : region_q == R_MMIO ? mmio_q : 32'h0;
`ifdef DMEM_CYCLE_CTR_EN
  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk)
    cycle <= rst ? 32'h0 : cycle + 32'h1;
`else
  assign cycle = 32'h0;
`endif
  // read-first word RAM with shifted byte enables; misaligned and reset-cycle writes dropped
  always_ff @(posedge clk) begin
    ram_q <= ram[idx];
    for (int i = 0; i < 4; i++)
      if (ram_we && wmask[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  // response path: region, offset and MMIO read value registered alongside the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      region_q <= R_NONE;
      off_q <= 2'b0;
      mmio_q <= 32'h0;
      misalign <= 1'b0;
    end else begin
      region_q <= is_ram ? R_RAM : R_MMIO;
      off_q <= off;
      mmio_q <= mmio_rd;
      misalign <= is_ram & mis;
    end
  end
  // GPIO register, byte enables taken straight from d_we
  always_ff @(posedge clk) begin
    if (rst) gpio_out <= 32'h0;
    else
      for (int i = 0; i < 4; i++)
        if (is_gpio && d_we[i]) gpio_out[8*i +: 8] <= d_wr_data[8*i +: 8];
  end
  // TX FIFO: a full FIFO still accepts a push when the head pops in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        fifo[wp] <= d_wr_data[7:0];
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (is_tx && d_we == 4'b0) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder
module tb_dmem_responder;
  logic clk = 0, rst = 1, tx_ready = 0, tx_valid, misalign;
  logic [31:0] d_addr = 0, d_wr_data = 0, d_rd_data, gpio_out, rd, e;
  logic [3:0] d_we = 0;
  logic [7:0] tx_data;
  logic [31:0] exp_q[$];
  logic [7:0] tx_q[$];
  int checks = 0, errors = 0, m_cnt = 0;
  logic m_ovf = 0;
  localparam logic [31:0] TXA = 32'h1000_0000, CYA = 32'h1000_0004, GPA = 32'h1000_0008, NOA = 32'h2000_0000;
  dmem_responder dut (.clk(clk), .rst(rst), .d_addr(d_addr), .d_we(d_we), .d_wr_data(d_wr_data),
    .d_rd_data(d_rd_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .gpio_out(gpio_out), .misalign(misalign));
  always #5 clk = ~clk;
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd, output logic [31:0] r);
    d_addr = a;
    d_we = we;
    d_wr_data = wd;
    @(posedge clk);
    #1;
    r = d_rd_data;
  endtask
  task automatic tx_push(input logic [7:0] b);
    if (tx_ready && m_cnt > 0) begin
      void'(tx_q.pop_front());
      m_cnt--;
    end
    if (m_cnt < 8) begin
      tx_q.push_back(b);
      m_cnt++;
    end else m_ovf = 1;
    access(TXA, 4'b0001, {24'h0, b}, rd);
  endtask
  task automatic tx_status(input string nm);
    exp_q.push_back({29'b0, m_ovf, m_cnt == 8, m_cnt == 0});
    m_ovf = 0;
    access(TXA, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL %s got=%h exp=%h", nm, rd, e); end
  endtask
  task automatic tx_drain(input string nm);
    tx_ready = 1;
    for (int i = 0; i < 8 && tx_q.size() > 0; i++) begin
      checks++; if ({tx_valid, tx_data} !== {1'b1, tx_q[0]}) begin errors++; $display("FAIL %s[%0d] got=%b/%h exp=1/%h", nm, i, tx_valid, tx_data, tx_q[0]); end
      void'(tx_q.pop_front());
      m_cnt--;
      access(NOA, 4'b0, 32'h0, rd);
    end
    tx_ready = 0;
    checks++; if ({tx_valid, tx_data} !== 9'h0) begin errors++; $display("FAIL %s_empty got=%b/%h exp=0/00", nm, tx_valid, tx_data); end
  endtask
  task automatic test_reset;
    rst = 1;
    access(NOA, 4'b0, 32'h0, rd);
    access(TXA, 4'b0001, 32'h77, rd);
    rst = 0;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_rd got=%h exp=0", rd); end
    checks++; if ({tx_valid, tx_data, misalign} !== 10'h0) begin errors++; $display("FAIL rst_tx got=%b/%h/%b exp=0", tx_valid, tx_data, misalign); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL rst_gpio got=%h exp=0", gpio_out); end
  endtask
  task automatic test_ram;
    access(32'h100, 4'b1111, 32'hDEADBEEF, rd);
    exp_q.push_back(32'hDEADBEEF);
    access(32'h100, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL lw got=%h exp=%h", rd, e); end
    access(32'h100, 4'b1111, 32'h11223344, rd);
    access(32'h103, 4'b0001, 32'hAB, rd);
    exp_q.push_back(32'h0000_00AB);
    exp_q.push_back(32'hAB22_3344);
    access(32'h103, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL lbu got=%h exp=%h", rd, e); end
    access(32'h100, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL lw_sb got=%h exp=%h", rd, e); end
    exp_q.push_back(32'hAB22_3344);
    exp_q.push_back(32'hCAFE_F00D);
    access(32'h100, 4'b1111, 32'hCAFEF00D, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL read_first got=%h exp=%h", rd, e); end
    access(32'h100, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL read_new got=%h exp=%h", rd, e); end
    access(32'h102, 4'b0011, 32'h1234, rd);
    exp_q.push_back(32'h0000_1234);
    access(32'h102, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL lhu got=%h exp=%h", rd, e); end
  endtask
  task automatic test_misalign;
    logic [31:0] a [2] = '{32'h103, 32'h101};
    logic [3:0] m [2] = '{4'b0011, 4'b1111};
    for (int i = 0; i < 2; i++) begin
      access(a[i], m[i], 32'hFFFFFFFF, rd);
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse%0d got=%b exp=1", i, misalign); end
      exp_q.push_back(32'h1234_F00D);
      access(32'h100, 4'b0, 32'h0, rd);
      e = exp_q.pop_front();
      checks++; if ({misalign, rd} !== {1'b0, e}) begin errors++; $display("FAIL mis_keep%0d got=%b/%h exp=0/%h", i, misalign, rd, e); end
    end
  endtask
  task automatic test_gpio;
    access(GPA, 4'b1111, 32'h12345678, rd);
    checks++; if (gpio_out !== 32'h12345678) begin errors++; $display("FAIL gpio_w got=%h exp=12345678", gpio_out); end
    access(GPA, 4'b0010, 32'h0000AB00, rd);
    exp_q.push_back(32'h1234AB78);
    exp_q.push_back(32'h0);
    access(GPA + 3, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if ({gpio_out, rd} !== {e, e}) begin errors++; $display("FAIL gpio_mask got=%h/%h exp=%h", gpio_out, rd, e); end
    access(NOA, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL unmapped got=%h exp=%h", rd, e); end
  endtask
  task automatic test_fifo_ovf;
    for (int i = 0; i < 9; i++) tx_push(8'h10 + 8'(i));
    tx_status("status_ovf");
    tx_status("status_reread");
    tx_drain("drain_ovf");
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) tx_push(8'h20 + 8'(i));
    tx_ready = 1;
    tx_push(8'h99);
    tx_ready = 0;
    tx_status("status_full_pp");
    tx_drain("drain_pp");
  endtask
  task automatic test_cycle;
    logic [31:0] c0, c1;
    rst = 1;
    access(NOA, 4'b0, 32'h0, rd);
    rst = 0;
    for (int i = 0; i < 9; i++) access(NOA, 4'b0, 32'h0, rd);
`ifdef DMEM_CYCLE_CTR_EN
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd10);
`else
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
`endif
    access(CYA, 4'b0, 32'h0, c0);
    access(CYA, 4'b0, 32'h0, c1);
    e = exp_q.pop_front();
    checks++; if (c0 !== e) begin errors++; $display("FAIL cycle10 got=%h exp=%h", c0, e); end
    e = exp_q.pop_front();
    checks++; if (c1 !== e) begin errors++; $display("FAIL cycle11 got=%h exp=%h", c1, e); end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) tx_push(8'h40 + 8'(i));
    access(32'h300, 4'b1111, 32'h1111, rd);
    rst = 1;
    access(TXA, 4'b0001, 32'h55, rd);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", tx_valid); end
    access(32'h300, 4'b1111, 32'h2222, rd);
    rst = 0;
    tx_q.delete();
    m_cnt = 0;
    m_ovf = 0;
    exp_q.push_back(32'h1111);
    access(32'h300, 4'b0, 32'h0, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL rst_wr_drop got=%h exp=%h", rd, e); end
    tx_status("status_after_rst");
  endtask
  initial begin
    test_reset();
    test_ram();
    test_misalign();
    test_gpio();
    test_fifo_ovf();
    test_back_to_back();
    test_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
